// File: rtl/dc_4bit_timer.sv
// Loadable down-counting timer with terminal-count pulse and optional auto-reload.
// Sits beside the 4-bit up counter and provides delay/timeout generation.
module dc_4bit_timer #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;

    case (state)
      IDLE: begin
        if (load) begin
          count_nxt  = load_val;
          reload_nxt = load_val;
        end else if (start && (count != '0)) begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (load) begin
          count_nxt  = load_val;
          reload_nxt = load_val;
          if (load_val == '0) state_nxt = DONE;
        end else if (en && (count != '0)) begin
          // The zero guard keeps the count from ever wrapping to all-ones.
          count_nxt = count - WIDTH'(1);
          if (count == WIDTH'(1)) state_nxt = DONE;
        end
      end

      DONE: begin
        if (load) begin
          count_nxt  = load_val;
          reload_nxt = load_val;
          state_nxt  = IDLE;
        end else if (AUTO_RELOAD && (reload != '0)) begin
          count_nxt = reload;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
    end
  end

  assign out  = count;
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign zero = (count == '0);

endmodule

// File: tb/tb_dc_4bit_timer.sv
// Self-checking bench for dc_4bit_timer: one-shot and auto-reload instances share
// stimulus; directed table, corner sequences and random traffic against a model.
module tb_dc_4bit_timer;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       en, load, start;
  logic [3:0] load_val;

  logic [3:0] out0, out1;
  logic       busy0, busy1, done0, done1, zero0, zero1;

  int checks   = 0;
  int failures = 0;

  // Reference model state, index 0 = one-shot, 1 = auto-reload.
  int m_cnt[2];
  int m_rl[2];
  bit m_run[2];
  bit m_pulse[2];

  typedef struct {
    logic       ld;
    logic [3:0] lv;
    logic       st;
    logic       e;
    logic [3:0] x_out;
    logic       x_busy;
    logic       x_done;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  dc_4bit_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u_once (
    .clk(clk), .clear_n(clear_n), .en(en), .load(load), .load_val(load_val),
    .start(start), .out(out0), .busy(busy0), .done(done0), .zero(zero0)
  );

  dc_4bit_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u_auto (
    .clk(clk), .clear_n(clear_n), .en(en), .load(load), .load_val(load_val),
    .start(start), .out(out1), .busy(busy1), .done(done1), .zero(zero1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]   = 0;
      m_rl[i]    = 0;
      m_run[i]   = 1'b0;
      m_pulse[i] = 1'b0;
    end
  endfunction

  // One clock of the timer rules: a pulse cycle ends after one clock, a load
  // always captures, a running count drops by one per enabled clock.
  function automatic void model_step(input bit ld, input int lv, input bit st, input bit e);
    bit was_pulse;
    for (int i = 0; i < 2; i++) begin
      was_pulse  = m_pulse[i];
      m_pulse[i] = 1'b0;
      if (ld) begin
        m_cnt[i] = lv;
        m_rl[i]  = lv;
        if (m_run[i] && lv == 0) begin
          m_run[i]   = 1'b0;
          m_pulse[i] = 1'b1;
        end
      end else if (was_pulse) begin
        if (i == 1 && m_rl[i] > 0) begin
          m_cnt[i] = m_rl[i];
          m_run[i] = 1'b1;
        end
      end else if (m_run[i]) begin
        if (e) begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
          if (m_cnt[i] == 0) begin
            m_run[i]   = 1'b0;
            m_pulse[i] = 1'b1;
          end
        end
      end else if (st && m_cnt[i] > 0) begin
        m_run[i] = 1'b1;
      end
    end
  endfunction

  task automatic compare_models();
    check("once.out",  32'(out0),  32'(m_cnt[0]));
    check("once.busy", 32'(busy0), 32'(m_run[0]));
    check("once.done", 32'(done0), 32'(m_pulse[0]));
    check("once.zero", 32'(zero0), 32'(m_cnt[0] == 0));
    check("auto.out",  32'(out1),  32'(m_cnt[1]));
    check("auto.busy", 32'(busy1), 32'(m_run[1]));
    check("auto.done", 32'(done1), 32'(m_pulse[1]));
    check("auto.zero", 32'(zero1), 32'(m_cnt[1] == 0));
  endtask

  // Drive on the falling edge, let the rising edge act, compare 1 time unit later.
  task automatic step(input logic ld, input logic [3:0] lv, input logic st, input logic e);
    @(negedge clk);
    load     = ld;
    load_val = lv;
    start    = st;
    en       = e;
    @(posedge clk);
    #1;
    model_step(ld, int'(lv), st, e);
    compare_models();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".once.out"},  32'(out0),  32'd0);
    check({tag, ".once.busy"}, 32'(busy0), 32'd0);
    check({tag, ".once.done"}, 32'(done0), 32'd0);
    check({tag, ".once.zero"}, 32'(zero0), 32'd1);
    check({tag, ".auto.out"},  32'(out1),  32'd0);
    check({tag, ".auto.busy"}, 32'(busy1), 32'd0);
    check({tag, ".auto.done"}, 32'(done1), 32'd0);
    check({tag, ".auto.zero"}, 32'(zero1), 32'd1);
  endtask

  // Reset asserted between edges must clear everything without a clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    load     = 1'b0;
    start    = 1'b0;
    en       = 1'b0;
    load_val = 4'd0;
    clear_n  = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  initial begin
    int unsigned r;
    logic [3:0]  auto_seq [8];

    clear_n  = 1'b0;
    load     = 1'b0;
    start    = 1'b0;
    en       = 1'b0;
    load_val = 4'd0;
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    clear_n = 1'b1;

    // Directed vectors for the one-shot instance; expectations after each edge.
    vecs.push_back('{1'b1, 4'd5, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0});
    // pause: en 1,0,0,1,1,1
    vecs.push_back('{1'b1, 4'd4, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    // load beats start; en ignored in IDLE; mid-run reload of 9 at out = 2
    vecs.push_back('{1'b1, 4'd7, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'd9, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0});
    // load 0 in RUN goes straight to DONE
    vecs.push_back('{1'b1, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    // start with out = 0 is ignored
    vecs.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
    // load during DONE captures and returns to IDLE; start there is ignored
    vecs.push_back('{1'b1, 4'd2, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'd6, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].e);
      check($sformatf("vec%0d.out", i),  32'(out0),  32'(vecs[i].x_out));
      check($sformatf("vec%0d.busy", i), 32'(busy0), 32'(vecs[i].x_busy));
      check($sformatf("vec%0d.done", i), 32'(done0), 32'(vecs[i].x_done));
      check($sformatf("vec%0d.zero", i), 32'(zero0), 32'(vecs[i].x_out == 4'd0));
    end

    // Reset in the middle of a run aborts it with no done pulse afterwards.
    step(1'b1, 4'd9, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("midrun.busy_before", 32'(busy0), 32'd1);
    async_reset("midrun");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b1);
      check("post_reset.once.done", 32'(done0), 32'd0);
      check("post_reset.auto.done", 32'(done1), 32'd0);
    end

    // Full-scale count: 15 decrements to 0, then the count stays at 0.
    step(1'b1, 4'd15, 1'b0, 1'b0);
    check("max.load", 32'(out0), 32'd15);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("max.busy", 32'(busy0), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b1);
      check($sformatf("max.out%0d", i),  32'(out0),  32'(15 - i));
      check($sformatf("max.done%0d", i), 32'(done0), 32'(i == 15));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b1);
      check("max.nowrap", 32'(out0), 32'd0);
    end

    // Auto-reload: 3,2,1,0,3,2,1,0 with done on each zero; load 0 in DONE stops it.
    async_reset("pre_auto");
    step(1'b1, 4'd3, 1'b0, 1'b1);
    auto_seq = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'd0, (i == 0), 1'b1);
      check($sformatf("auto.seq_out%0d", i),  32'(out1),  32'(auto_seq[i]));
      check($sformatf("auto.seq_done%0d", i), 32'(done1), 32'(auto_seq[i] == 4'd0));
      check($sformatf("auto.seq_busy%0d", i), 32'(busy1), 32'(auto_seq[i] != 4'd0));
    end
    step(1'b1, 4'd0, 1'b0, 1'b1);
    check("auto.stop_out",  32'(out1),  32'd0);
    check("auto.stop_busy", 32'(busy1), 32'd0);
    check("auto.stop_done", 32'(done1), 32'd0);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("auto.idle_busy", 32'(busy1), 32'd0);

    // Random traffic against the model, with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        async_reset("rand");
      end else begin
        step(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
